// File: rtl/rob_commit_if.sv
// Head-of-ROB view, retirement outputs and store commit handshake for rob_commit_ctrl.
// The master side is the ROB/store path. The slave side is the commit controller.
interface rob_commit_if #(
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6
);
  logic [1:0]          head_valid;
  logic [1:0]          head_done;
  logic [1:0]          head_store;
  logic [1:0]          head_exc;
  logic [1:0]          head_we;
  logic [2*ARCH_W-1:0] head_rd;
  logic [2*PHYS_W-1:0] head_prd;
  logic [1:0]          rob_pop;
  logic [1:0]          arf_we;
  logic [2*ARCH_W-1:0] arf_addr;
  logic [2*PHYS_W-1:0] arf_prd;
  logic                st_req;
  logic                st_ack;
  logic                flush;

  modport master (
    output head_valid, head_done, head_store, head_exc, head_we, head_rd, head_prd, st_ack,
    input  rob_pop, arf_we, arf_addr, arf_prd, st_req, flush
  );

  modport slave (
    input  head_valid, head_done, head_store, head_exc, head_we, head_rd, head_prd, st_ack,
    output rob_pop, arf_we, arf_addr, arf_prd, st_req, flush
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Retires up to two oldest ROB entries per cycle in program order.
// Store commits are serialised through st_req/st_ack, and an excepting entry is followed by a flush pulse.
//   state   | meaning
//   RUN     | normal retirement of slot0/slot1
//   ST_WAIT | slot0 store waiting for memory ack
//   FLUSH   | one-cycle flush after an excepting retire
module rob_commit_ctrl #(
  parameter int ARCH_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rob_commit_if.slave      rob_if,
  output logic [CNT_W-1:0] commit_cnt_o
);
  typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_e;

  state_e           state_q, state_d;
  logic             st_req_q, flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       rdy;
  logic [1:0]       pop_d, we_d;
  logic             same_rd;

  assign rdy     = rob_if.head_valid & rob_if.head_done;
  assign same_rd = rob_if.head_rd[ARCH_W-1:0] == rob_if.head_rd[2*ARCH_W-1:ARCH_W];

  always_comb begin
    state_d = state_q;
    pop_d   = 2'd0;
    we_d    = 2'b00;
    unique case (state_q)
      RUN: begin
        if (rdy[0]) begin
          if (rob_if.head_exc[0]) begin
            pop_d   = 2'd1;
            we_d[0] = rob_if.head_we[0];
            state_d = FLUSH;
          end else if (rob_if.head_store[0]) begin
            state_d = ST_WAIT;
          end else begin
            pop_d   = 2'd1;
            we_d[0] = rob_if.head_we[0];
            if (rdy[1] && !rob_if.head_store[1] && !rob_if.head_exc[1]) begin
              pop_d   = 2'd2;
              we_d[1] = rob_if.head_we[1];
              // Younger slot owns the final mapping when both target the same rd
              if (rob_if.head_we[1] && same_rd) we_d[0] = 1'b0;
            end
          end
        end
      end
      ST_WAIT: begin
        if (rob_if.st_ack) begin
          pop_d   = 2'd1;
          we_d[0] = rob_if.head_we[0];
          state_d = RUN;
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
    if (rst_i) begin
      pop_d = 2'd0;
      we_d  = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      st_req_q <= 1'b0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      st_req_q <= (state_d == ST_WAIT);
      flush_q  <= (state_d == FLUSH);
      cnt_q    <= cnt_q + CNT_W'(pop_d);
    end
  end

  assign rob_if.rob_pop  = pop_d;
  assign rob_if.arf_we   = we_d;
  assign rob_if.arf_addr = rob_if.head_rd;
  assign rob_if.arf_prd  = rob_if.head_prd;
  assign rob_if.st_req   = st_req_q & ~rst_i;
  assign rob_if.flush    = flush_q & ~rst_i;
  assign commit_cnt_o    = cnt_q;
endmodule
